// File: rtl/mitchell_pkg.sv
// Shared definitions for the Mitchell multiplier datapath and its downstream accumulator.
package mitchell_pkg;

  localparam int unsigned SZ         = 8;
  localparam int unsigned PW_DEFAULT = 2 * SZ;
  localparam int unsigned Q_DEFAULT  = 3329;

  // Smallest r with 2**r >= value; usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

  localparam int unsigned QW_DEFAULT = clog2(Q_DEFAULT);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAcc  = 2'd1,
    StRed  = 2'd2,
    StOut  = 2'd3
  } state_e;

endpackage

// File: rtl/mitchell_modq_step.sv
// One step of the shift-and-subtract reduction: subtract Q<<k from acc when it fits.
module mitchell_modq_step #(
  parameter int unsigned ACC_W = 20,
  parameter int unsigned Q     = 3329,
  parameter int unsigned KBW   = 5
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [KBW-1:0]   k,
  output logic [ACC_W-1:0] res
);

  // One extra bit so Q<<k never wraps before the compare.
  logic [ACC_W:0] q_shl;

  always_comb begin
    q_shl = (ACC_W + 1)'(Q) << k;
    res   = ({1'b0, acc} >= q_shl) ? (acc - q_shl[ACC_W-1:0]) : acc;
  end

endmodule

// File: rtl/mitchell_dot_accum.sv
// Accumulates N Mitchell products per frame and emits the sum on a held valid/ready port.
// Define MITCHELL_MOD_Q_EN to reduce each sum mod Q before it is emitted.
module mitchell_dot_accum
  import mitchell_pkg::*;
#(
  parameter int unsigned PW    = PW_DEFAULT,
  parameter int unsigned N     = 16,
  parameter int unsigned ACC_W = 20,
  parameter int unsigned Q     = Q_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PW-1:0]    in_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum
);

  localparam int unsigned CW = clog2(N) + 1;

  if (N == 0 || ACC_W < PW + clog2(N) || Q < 2) begin : g_bad_cfg
    $error("mitchell_dot_accum: invalid parameter set");
  end

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;

`ifdef MITCHELL_MOD_Q_EN
  localparam int unsigned QW  = clog2(Q);
  localparam int unsigned KW  = ACC_W - QW;
  localparam int unsigned KBW = clog2(KW + 1) + 1;

  logic [KBW-1:0]   k_q, k_d;
  logic [ACC_W-1:0] red_acc;

  mitchell_modq_step #(
    .ACC_W (ACC_W),
    .Q     (Q),
    .KBW   (KBW)
  ) u_modq_step (
    .acc (acc_q),
    .k   (k_q),
    .res (red_acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) k_q <= '0;
    else        k_q <= k_d;
  end
`endif

  assign in_ready  = (state_q == StAcc);
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    out_sum_d   = out_sum_q;
`ifdef MITCHELL_MOD_Q_EN
    k_d         = k_q;
`endif

    unique case (state_q)
      StIdle: state_d = StAcc;
      StAcc: begin
        if (in_valid) begin
          acc_d = acc_q + ACC_W'(in_prod);
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) begin
`ifdef MITCHELL_MOD_Q_EN
            state_d = StRed;
            k_d     = KBW'(KW);
`else
            state_d = StOut;
`endif
          end
        end
      end
      StRed: begin
`ifdef MITCHELL_MOD_Q_EN
        acc_d = red_acc;
        if (k_q == '0) state_d = StOut;
        else           k_d     = k_q - 1'b1;
`else
        state_d = StIdle;
`endif
      end
      StOut: begin
        if (out_valid_q && out_ready) begin
          state_d = StAcc;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          // First OUT cycle captures the final sum; out_valid follows one edge later.
          out_valid_d = 1'b1;
          if (!out_valid_q) out_sum_d = acc_q;
        end
      end
      default: state_d = StIdle;
    endcase

    if (clr) begin
      state_d     = StAcc;
      acc_d       = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
    end
  end

endmodule

// File: tb/tb_mitchell_dot_accum.sv
// Self-checking bench for mitchell_dot_accum: cycle model plus directed and random frames.
// Honours MITCHELL_MOD_Q_EN the same way the design does.
module tb_mitchell_dot_accum;

  localparam int unsigned PW    = 16;
  localparam int unsigned N     = 16;
  localparam int unsigned ACC_W = 20;
  localparam int unsigned Q     = 3329;
`ifdef MITCHELL_MOD_Q_EN
  localparam int LAT_EDGES = 1 + (ACC_W - 12 + 1);
  localparam longint E_FULL = 1752;
  localparam longint E_BOUND = 0;
`else
  localparam int LAT_EDGES = 1;
  localparam longint E_FULL = 1040400;
  localparam longint E_BOUND = 998700;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [PW-1:0]    in_prod = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_sum;

  mitchell_dot_accum #(
    .PW    (PW),
    .N     (N),
    .ACC_W (ACC_W),
    .Q     (Q)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting on DUT (t=%0t)", name, $time);
  endtask

  function automatic longint reduce(input longint s);
`ifdef MITCHELL_MOD_Q_EN
    return s % longint'(Q);
`else
    return s % (64'sd1 << ACC_W);
`endif
  endfunction

  // Behavioural model: frame progress, pending result and its remaining latency.
  int     cyc = 0;
  bit     m_fresh = 1'b1;
  bit     m_busy = 1'b0;
  bit     m_ov = 1'b0;
  int     m_cnt = 0;
  int     m_wait = 0;
  longint m_sum = 0;
  longint m_exp = 0;
  longint got[$];
  int     last_acc = 0;
  int     rise = 0;
  bit     prev_ov = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_in_ready", longint'(in_ready), 0);
      chk("rst_out_sum", longint'(out_sum), 0);
      m_fresh = 1'b1; m_busy = 1'b0; m_ov = 1'b0; m_cnt = 0; m_sum = 0;
    end else begin
      chk("in_ready", longint'(in_ready), longint'(!m_fresh && !m_busy));
      chk("out_valid", longint'(out_valid), longint'(m_ov));
      if (m_ov) chk("out_sum", longint'(out_sum), m_exp);
      if (out_valid && !prev_ov) rise = cyc;
      if (clr) begin
        m_fresh = 1'b0; m_busy = 1'b0; m_ov = 1'b0; m_cnt = 0; m_sum = 0;
      end else if (m_fresh) begin
        m_fresh = 1'b0;
      end else if (!m_busy) begin
        if (in_valid) begin
          m_sum += longint'(in_prod);
          m_cnt++;
          last_acc = cyc;
          if (m_cnt == N) begin
            m_busy = 1'b1;
            m_wait = LAT_EDGES;
            m_exp  = reduce(m_sum);
          end
        end
      end else if (m_ov) begin
        if (out_ready) begin
          got.push_back(longint'(out_sum));
          m_busy = 1'b0; m_ov = 1'b0; m_cnt = 0; m_sum = 0;
        end
      end else begin
        m_wait--;
        if (m_wait == 0) m_ov = 1'b1;
      end
    end
    prev_ov = out_valid;
  end

  task automatic beat(input logic [PW-1:0] v);
    int g;
    g = 0;
    in_valid = 1'b1;
    in_prod  = v;
    @(negedge clk);
    while (!in_ready && g < 200) begin
      g++;
      @(negedge clk);
    end
    if (!in_ready) timeout_fail("beat");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_got(input int n);
    int g;
    g = 0;
    while (got.size() < n && g < 100) begin
      g++;
      @(negedge clk);
    end
    if (got.size() < n) timeout_fail("result");
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int g;
    g = 0;
    @(negedge clk);
    while (!out_valid && g < 100) begin
      g++;
      @(negedge clk);
    end
    if (!out_valid) timeout_fail("out_valid");
  endtask

  function automatic longint last_got();
    return (got.size() > 0) ? got[got.size()-1] : -1;
  endfunction

  initial begin
    #200000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full-scale frame and latency
    out_ready = 1'b1;
    n = got.size();
    for (int i = 0; i < 16; i++) beat(16'd65025);
    wait_got(n + 1);
    chk("t1_sum", last_got(), E_FULL);
    // +1: accept is logged at the negedge before its edge
    chk("t1_latency", longint'(rise - last_acc), longint'(LAT_EDGES + 1));

    // Bubbles on alternate cycles
    n = got.size();
    for (int i = 1; i <= 16; i++) begin
      beat(PW'(i));
      @(posedge clk);
      #1;
    end
    wait_got(n + 1);
    chk("t2_sum", last_got(), 136);

    // Backpressure in OUT, then immediate next frame
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) beat(16'd2);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", longint'(out_valid), 1);
      chk("t3_hold_sum", longint'(out_sum), 32);
      chk("t3_hold_ready", longint'(in_ready), 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    n = got.size();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_prod   = 16'd7;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("t3_next_ready", longint'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("t3_taken", longint'(got.size()), longint'(n + 1));
    chk("t3_first_sum", last_got(), 32);
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) beat(16'd7);
    wait_got(n + 2);
    chk("t3_next_sum", last_got(), 112);

    // Abort mid-frame with a simultaneous beat
    n = got.size();
    for (int i = 0; i < 7; i++) beat(16'd100);
    clr = 1'b1; in_valid = 1'b1; in_prod = 16'd100;
    @(posedge clk);
    #1;
    clr = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 16; i++) beat(16'd1);
    wait_got(n + 1);
    chk("t4_sum", last_got(), 16);
    chk("t4_count", longint'(got.size()), longint'(n + 1));

    // Reset while out_valid is high
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) beat(16'd5);
    wait_valid();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", longint'(out_valid), 0);
    chk("t5_async_sum", longint'(out_sum), 0);
    chk("t5_async_ready", longint'(in_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_ready_idle", longint'(in_ready), 0);
    @(negedge clk);
    chk("t5_ready_acc", longint'(in_ready), 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    n = got.size();
    for (int i = 0; i < 16; i++) beat(16'd0);
    wait_got(n + 1);
    chk("t5_sum", last_got(), 0);

    // Reduction boundaries: exact multiple of Q, and one below Q
    n = got.size();
    for (int i = 0; i < 15; i++) beat(16'd62419);
    beat(16'd62415);
    wait_got(n + 1);
    chk("t6_multiple", last_got(), E_BOUND);
    for (int i = 0; i < 16; i++) beat(16'd208);
    wait_got(n + 2);
    chk("t6_below_q", last_got(), 3328);

    // Random traffic with bubbles, backpressure and rare aborts
    n = got.size();
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_prod   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : PW'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      clr       = ($urandom_range(0, 299) == 0);
    end
    @(posedge clk);
    #1;
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    chk("rand_frames_seen", longint'(got.size() - n >= 20), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
